// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder using a single full-adder cell and a
// registered carry. Operands are processed LSB first, one bit per clock,
// under a start/busy/done handshake. The result is held in output registers.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter width chosen so that WIDTH=1 still gets a legal counter.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             bitSum;
  logic             bitCarry;
  logic             lastBit;
  logic             accept;

  // Register all state; reset aborts any operation and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one full-adder step per RUN cycle, load on accept.
  always_comb begin
    state_d  = state_q;
    aSr_d    = aSr_q;
    bSr_d    = bSr_q;
    psum_d   = psum_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;

    bitSum   = aSr_q[0] ^ bSr_q[0] ^ carry_q;
    bitCarry = (aSr_q[0] & bSr_q[0]) | (aSr_q[0] & carry_q) | (bSr_q[0] & carry_q);
    lastBit  = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
        end
      end
      RUN: begin
        carry_d          = bitCarry;
        aSr_d            = aSr_q >> 1;
        bSr_d            = bSr_q >> 1;
        psum_d           = psum_q >> 1;
        psum_d[WIDTH-1]  = bitSum;
        cnt_d            = cnt_q + CW'(1);
        if (lastBit) begin
          sum_d   = psum_d;
          cout_d  = bitCarry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      aSr_d   = a;
      bSr_d   = b;
      carry_d = cin;
      cnt_d   = '0;
      psum_d  = '0;
      state_d = RUN;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
